// File: rtl/spec_read_fifo.sv
// Speculative-read FIFO: reads are tentative until commit, or rewound by revert.
// Latency: a written entry is visible on valid_out/data_out one cycle after the write.
// Backpressure: ready_in = ~full; read-but-uncommitted entries still occupy space.
// Optional build macro SPEC_READ_FIFO_PENDING_EN adds the 'pending' output (count - spec_count).
module spec_read_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     ready_in,
    input  logic                     valid_in,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     ready_out,
    output logic                     valid_out,
    output logic [WIDTH-1:0]         data_out,
    input  logic                     commit,
    input  logic                     revert
`ifdef SPEC_READ_FIFO_PENDING_EN
    ,
    output logic [$clog2(DEPTH):0]   pending
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_spec_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_spec_count;

    logic             w_full;
    logic             w_wr;
    logic             w_rd;
    logic [AW-1:0]    w_spec_rd_ptr_adv;
    logic [CW-1:0]    w_spec_count_adv;
    logic [CW-1:0]    w_count_wr;

    // Handshake qualification and the "normal progress" next values shared by all branches.
    always_comb begin
        w_full            = (r_count == CW'(DEPTH));
        w_wr              = valid_in & ~w_full;
        w_rd              = ready_out & (r_spec_count != '0);
        w_spec_rd_ptr_adv = r_spec_rd_ptr + AW'(w_rd);
        w_spec_count_adv  = r_spec_count + CW'(w_wr) - CW'(w_rd);
        w_count_wr        = r_count + CW'(w_wr);
    end

    assign ready_in  = ~w_full;
    assign valid_out = (r_spec_count != '0);
    assign data_out  = r_mem[r_spec_rd_ptr];

`ifdef SPEC_READ_FIFO_PENDING_EN
    assign pending = r_count - r_spec_count;
`endif

    // Storage write; contents are deliberately not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointer/occupancy update: commit wins over revert, writes always land.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_spec_rd_ptr <= '0;
            r_count       <= '0;
            r_spec_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (commit) begin
                // Retire every speculative read, including one in this cycle.
                r_rd_ptr      <= w_spec_rd_ptr_adv;
                r_spec_rd_ptr <= w_spec_rd_ptr_adv;
                r_count       <= w_spec_count_adv;
                r_spec_count  <= w_spec_count_adv;
            end else if (revert) begin
                // Rewind to the committed point; a same-cycle read is dropped.
                r_spec_rd_ptr <= r_rd_ptr;
                r_count       <= w_count_wr;
                r_spec_count  <= w_count_wr;
            end else begin
                r_spec_rd_ptr <= w_spec_rd_ptr_adv;
                r_count       <= w_count_wr;
                r_spec_count  <= w_spec_count_adv;
            end
        end
    end

endmodule

// File: tb/tb_spec_read_fifo.sv
// Directed bench for spec_read_fifo: vector table plus hand sequences for fill/drain, wrap and mid-stream reset.
module tb_spec_read_fifo;

    logic       clk;
    logic       reset;
    logic       ready_in;
    logic       valid_in;
    logic [7:0] data_in;
    logic       ready_out;
    logic       valid_out;
    logic [7:0] data_out;
    logic       commit;
    logic       revert;
`ifdef SPEC_READ_FIFO_PENDING_EN
    logic [4:0] pending;
`endif

    int checks;
    int errors;

    spec_read_fifo #(.WIDTH(8), .DEPTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .ready_in  (ready_in),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .commit    (commit),
        .revert    (revert)
`ifdef SPEC_READ_FIFO_PENDING_EN
        ,
        .pending   (pending)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vin;
        logic [7:0] din;
        logic       rout;
        logic       cmt;
        logic       rev;
        logic       e_rdy;
        logic       e_vo;
        logic [7:0] e_do;
        logic [4:0] e_cnt;
        logic [4:0] e_sc;
        logic [3:0] e_rdp;
    } vec_t;

    localparam int NV = 21;
    vec_t vt [NV];

    function automatic vec_t mk(input logic rst, input logic vin, input logic [7:0] din,
                                input logic rout, input logic cmt, input logic rev,
                                input logic e_rdy, input logic e_vo, input logic [7:0] e_do,
                                input logic [4:0] e_cnt, input logic [4:0] e_sc,
                                input logic [3:0] e_rdp);
        vec_t v;
        v.rst = rst; v.vin = vin; v.din = din; v.rout = rout; v.cmt = cmt; v.rev = rev;
        v.e_rdy = e_rdy; v.e_vo = e_vo; v.e_do = e_do;
        v.e_cnt = e_cnt; v.e_sc = e_sc; v.e_rdp = e_rdp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; valid_in = 1'b0; data_in = 8'h00;
        ready_out = 1'b0; commit = 1'b0; revert = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    byte unsigned q [$];
    logic [7:0]   exp_b;
    int           nxt;

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();

        //            rst   vin   din    rout  cmt   rev    rdy   vo    do     cnt    sc     rdp
        vt[0]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 8'h00, 5'd0, 5'd0, 4'd0);
        vt[1]  = mk(1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 8'hA1, 5'd1, 5'd1, 4'd0);
        vt[2]  = mk(1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 8'hA1, 5'd2, 5'd2, 4'd0);
        vt[3]  = mk(1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 8'hA1, 5'd3, 5'd3, 4'd0);
        vt[4]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 8'hA2, 5'd3, 5'd2, 4'd0);
        vt[5]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 8'hA3, 5'd3, 5'd1, 4'd0);
        vt[6]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 8'hA1, 5'd3, 5'd3, 4'd0);
        vt[7]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1,  1'b1, 1'b1, 8'hA1, 5'd3, 5'd3, 4'd0);
        vt[8]  = mk(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 8'h00, 5'd0, 5'd0, 4'd0);
        vt[9]  = mk(1'b0, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 8'hB0, 5'd1, 5'd1, 4'd0);
        vt[10] = mk(1'b0, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 8'hB0, 5'd2, 5'd2, 4'd0);
        vt[11] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0,  1'b1, 1'b1, 8'hB1, 5'd1, 5'd1, 4'd1);
        vt[12] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 8'hB1, 5'd1, 5'd1, 4'd1);
        vt[13] = mk(1'b0, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 8'hB1, 5'd2, 5'd2, 4'd1);
        vt[14] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 8'hB2, 5'd2, 5'd1, 4'd1);
        vt[15] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 8'h00, 5'd2, 5'd0, 4'd1);
        vt[16] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1,  1'b1, 1'b0, 8'h00, 5'd0, 5'd0, 4'd3);
        vt[17] = mk(1'b0, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 8'hC0, 5'd1, 5'd1, 4'd3);
        vt[18] = mk(1'b0, 1'b1, 8'hC5, 1'b1, 1'b0, 1'b1,  1'b1, 1'b1, 8'hC0, 5'd2, 5'd2, 4'd3);
        vt[19] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 8'hC5, 5'd2, 5'd1, 4'd3);
        vt[20] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 8'h00, 5'd0, 5'd0, 4'd5);

        for (int i = 0; i < NV; i++) begin
            reset = vt[i].rst; valid_in = vt[i].vin; data_in = vt[i].din;
            ready_out = vt[i].rout; commit = vt[i].cmt; revert = vt[i].rev;
            step();
            chk($sformatf("v%0d ready_in", i), 32'(ready_in), 32'(vt[i].e_rdy));
            chk($sformatf("v%0d valid_out", i), 32'(valid_out), 32'(vt[i].e_vo));
            if (vt[i].e_vo)
                chk($sformatf("v%0d data_out", i), 32'(data_out), 32'(vt[i].e_do));
            chk($sformatf("v%0d count", i), 32'(dut.r_count), 32'(vt[i].e_cnt));
            chk($sformatf("v%0d spec_count", i), 32'(dut.r_spec_count), 32'(vt[i].e_sc));
            chk($sformatf("v%0d rd_ptr", i), 32'(dut.r_rd_ptr), 32'(vt[i].e_rdp));
        end

        // Fill to capacity, overflow attempt, read everything without commit, then commit.
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            valid_in = 1'b1; data_in = 8'(8'h10 + i);
            step();
        end
        chk("full ready_in", 32'(ready_in), 32'd0);
        chk("full count", 32'(dut.r_count), 32'd16);
        data_in = 8'hFF;
        step();
        valid_in = 1'b0;
        chk("overflow count", 32'(dut.r_count), 32'd16);
        chk("overflow head", 32'(data_out), 32'h10);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain data %0d", i), 32'(data_out), 32'(8'h10 + i));
            ready_out = 1'b1;
            step();
        end
        chk("drained valid_out", 32'(valid_out), 32'd0);
        chk("drained ready_in", 32'(ready_in), 32'd0);
        chk("drained count", 32'(dut.r_count), 32'd16);
        step();
        chk("underflow spec_count", 32'(dut.r_spec_count), 32'd0);
        ready_out = 1'b0; commit = 1'b1;
        step();
        commit = 1'b0;
        chk("commit ready_in", 32'(ready_in), 32'd1);
        chk("commit count", 32'(dut.r_count), 32'd0);

        // Wrap-around stream with a scoreboard queue; reads skipped every third cycle.
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        nxt = 0;
        for (int k = 0; k < 40; k++) begin
            logic do_rd;
            do_rd = valid_out && ((k % 3) != 2);
            if (do_rd) begin
                exp_b = q.pop_front();
                chk($sformatf("wrap data %0d", k), 32'(data_out), 32'(exp_b));
            end
            valid_in = 1'b1; data_in = 8'(8'h40 + nxt);
            if (ready_in) begin
                q.push_back(8'(8'h40 + nxt));
                nxt++;
            end
            ready_out = do_rd; commit = 1'b1;
            step();
        end
        chk("wrap count", 32'(dut.r_count), 32'(q.size()));
        chk("wrap order head", 32'(data_out), 32'(q[0]));

        // Reset in the middle of traffic with a pending speculative read.
        commit = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
        step();
        reset = 1'b1; valid_in = 1'b1; data_in = 8'h99; commit = 1'b1; revert = 1'b1;
        step();
        idle_inputs();
        chk("mid reset valid_out", 32'(valid_out), 32'd0);
        chk("mid reset ready_in", 32'(ready_in), 32'd1);
        chk("mid reset count", 32'(dut.r_count), 32'd0);
`ifdef SPEC_READ_FIFO_PENDING_EN
        chk("mid reset pending", 32'(pending), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spec_read_fifo.md
SPEC_READ_FIFO -- requirements
Module: spec_read_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: entry count; power of two, >= 2.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port ready_in  output  1: space available, equal to ~full.
REQ-006 SHALL have port valid_in  input  1: producer presents data_in.
REQ-007 SHALL have port data_in  input  WIDTH: write data.
REQ-008 SHALL have port ready_out  input  1: consumer takes data_out this cycle (speculative read).
REQ-009 SHALL have port valid_out  output  1: an unread entry exists, equal to spec_count != 0.
REQ-010 SHALL have port data_out  output  WIDTH: entry at spec_rd_ptr, combinational from storage.
REQ-011 SHALL have port commit  input  1: retire all speculative reads so far and free their entries.
REQ-012 SHALL have port revert  input  1: rewind all uncommitted reads so entries are re-presented.

Function
REQ-013 SHALL keep wr_ptr, committed rd_ptr and spec_rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-014 SHALL keep count (committed occupancy) and spec_count (unread entries), each $clog2(DEPTH)+1 bits, range 0..DEPTH.
REQ-015 SHALL define full = (count == DEPTH); capacity is exactly DEPTH entries.
REQ-016 SHALL perform write = valid_in && ~full: store data_in at wr_ptr, increment wr_ptr, count, spec_count.
REQ-017 SHALL perform read = ready_out && valid_out: increment spec_rd_ptr, decrement spec_count; count unchanged.
REQ-018 SHALL make a written entry visible on valid_out/data_out the cycle after the write (latency 1).
REQ-019 SHALL on commit set rd_ptr to spec_rd_ptr, or spec_rd_ptr+1 if read in same cycle; read included in commit.
REQ-020 SHALL on commit set count to spec_count plus write minus read of that cycle; freed space raises ready_in next cycle.
REQ-021 SHALL on revert without commit set spec_rd_ptr to rd_ptr and spec_count to count plus write; a same-cycle read is discarded.
REQ-022 SHALL treat commit and revert asserted together as commit only.
REQ-023 SHALL always accept a same-cycle write regardless of commit/revert; writes are never speculative.
REQ-024 SHALL leave state unchanged on commit or revert with no outstanding speculative reads (no-op).
REQ-025 SHALL hold ready_in low while full even if all entries are read but uncommitted; no overwrite of uncommitted entries.
REQ-026 SHALL ignore ready_out when valid_out is low and valid_in when full (no underflow/overflow).

Reset
REQ-027 SHALL on reset clear wr_ptr, rd_ptr, spec_rd_ptr, count, spec_count to 0; storage contents not reset.
REQ-028 SHALL drive ready_in=1, valid_out=0 the cycle after reset; reset overrides any concurrent write/read/commit/revert.
REQ-029 SHALL discard all committed and speculative state when reset asserts mid-operation.

Configuration
REQ-030 SHALL when SPEC_READ_FIFO_PENDING_EN is defined add output port pending  output  $clog2(DEPTH)+1: count - spec_count, registered-state derived, 0 after reset.
REQ-031 SHALL when SPEC_READ_FIFO_PENDING_EN is undefined omit the pending port; all other behaviour identical.

Verification
REQ-032 SHALL cover: write 0xA1,0xA2,0xA3; read 2; revert -> next cycle data_out=0xA1, spec_count=3, count=3.
REQ-033 SHALL cover: DEPTH=16 fill 16 entries, read all 16 without commit -> ready_in=0, valid_out=0; commit -> ready_in=1 next cycle, count=0.
REQ-034 SHALL cover: read 0xB0 and commit same cycle -> rd_ptr advances 1, count drops 1, 0xB0 never re-presented after later revert.
REQ-035 SHALL cover: commit+revert same cycle after 2 reads -> behaves as commit, count decremented by 2.
REQ-036 SHALL cover: revert with same-cycle read and write of 0xC5 -> read discarded, 0xC5 retained, spec_count = count+1.
REQ-037 SHALL cover: wrap-around, 40 write/read/commit cycles at DEPTH=16 -> data order preserved; reset mid-stream -> valid_out=0, ready_in=1, pending=0 when enabled.
